// File: rtl/bird_datapath.sv
// Vertical motion datapath for the player bird: divided-rate position/velocity
// update with clamping, plus ceiling/ground/pipe collision detection.
module bird_datapath #(
  parameter int Y_WIDTH   = 7,
  parameter int X_WIDTH   = 8,
  parameter int Y_START   = 60,
  parameter int Y_GROUND  = 112,
  parameter int BIRD_X    = 20,
  parameter int BIRD_W    = 4,
  parameter int BIRD_H    = 4,
  parameter int PIPE_W    = 8,
  parameter int TICK_DIV  = 833333,
  parameter int RISE_STEP = 2,
  parameter int V_MAX     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               move,
  input  logic               press_key,
  input  logic [X_WIDTH-1:0] pipe_x,
  input  logic [Y_WIDTH-1:0] gap_top,
  input  logic [Y_WIDTH-1:0] gap_bottom,
  output logic [Y_WIDTH-1:0] bird_y,
  output logic               touched,
  output logic               frame_tick
);

  localparam int CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int VW  = (V_MAX > 0) ? $clog2(V_MAX + 1) : 1;
  localparam int SW  = Y_WIDTH + 2;
  localparam int YW1 = Y_WIDTH + 1;
  localparam int XW1 = X_WIDTH + 1;

  localparam logic [CW-1:0]        CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic signed [SW-1:0] Y_MAX    = SW'(Y_GROUND - BIRD_H);
  localparam logic signed [SW-1:0] RISE     = SW'(RISE_STEP);
  localparam logic [VW-1:0]        VEL_CAP  = VW'(V_MAX);
  localparam logic [Y_WIDTH-1:0]   Y_INIT   = Y_WIDTH'(Y_START);

  logic [Y_WIDTH-1:0] y_reg, y_next;
  logic [VW-1:0]      vel_reg, vel_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               touched_reg, touched_next;
  logic               frame_tick_reg, frame_tick_next;

  logic               active, tick;
  logic signed [SW-1:0] y_ext, vel_ext, y_sum;
  logic [Y_WIDTH-1:0] y_clamped;
  logic [VW-1:0]      vel_fall;

  logic [YW1-1:0]     bird_bottom_edge, bird_last_row;
  logic [XW1-1:0]     pipe_left, pipe_right;
  logic               hit_ceiling, hit_ground, cols_overlap, outside_gap, hit;

  // Motion advances only while enabled and not yet collided.
  assign active = move && !touched_reg;
  assign tick   = active && (cnt_reg == CNT_LAST);

  // Position arithmetic is done signed and two bits wider so both over- and
  // under-flow are visible before the clamp.
  always_comb begin
    y_ext   = SW'(y_reg);
    vel_ext = SW'(vel_reg);
    if (press_key) y_sum = y_ext - RISE;
    else           y_sum = y_ext + vel_ext;

    if (y_sum < 0)          y_clamped = '0;
    else if (y_sum > Y_MAX) y_clamped = Y_WIDTH'(Y_MAX);
    else                    y_clamped = Y_WIDTH'(y_sum);

    if (vel_reg >= VEL_CAP) vel_fall = VEL_CAP;
    else                    vel_fall = vel_reg + VW'(1);
  end

  // Collision terms on the registered position, widened by one bit so sums never wrap.
  always_comb begin
    bird_bottom_edge = YW1'(y_reg) + YW1'(BIRD_H);
    bird_last_row    = YW1'(y_reg) + YW1'(BIRD_H - 1);
    pipe_left        = XW1'(pipe_x);
    pipe_right       = XW1'(pipe_x) + XW1'(PIPE_W);

    hit_ceiling  = (y_reg == '0);
    hit_ground   = (bird_bottom_edge >= YW1'(Y_GROUND));
    cols_overlap = (pipe_left < XW1'(BIRD_X + BIRD_W)) && (pipe_right > XW1'(BIRD_X));
    outside_gap  = (y_reg < gap_top) || (bird_last_row > YW1'(gap_bottom));
    hit          = hit_ceiling || hit_ground || (cols_overlap && outside_gap);
  end

  always_comb begin
    y_next          = y_reg;
    vel_next        = vel_reg;
    cnt_next        = cnt_reg;
    touched_next    = touched_reg;
    frame_tick_next = 1'b0;

    if (start) begin
      y_next       = Y_INIT;
      vel_next     = '0;
      cnt_next     = '0;
      touched_next = 1'b0;
    end else begin
      if (tick) begin
        cnt_next        = '0;
        y_next          = y_clamped;
        vel_next        = press_key ? '0 : vel_fall;
        frame_tick_next = 1'b1;
      end else if (active) begin
        cnt_next = cnt_reg + CW'(1);
      end
      // Sticky: once set it stays until start or reset.
      if (move && hit) touched_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_reg          <= Y_INIT;
      vel_reg        <= '0;
      cnt_reg        <= '0;
      touched_reg    <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      y_reg          <= y_next;
      vel_reg        <= vel_next;
      cnt_reg        <= cnt_next;
      touched_reg    <= touched_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign bird_y     = y_reg;
  assign touched    = touched_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath with a 4-clock motion tick.
module tb_bird_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, move, press_key;
  logic [7:0] pipe_x;
  logic [6:0] gap_top, gap_bottom;
  logic [6:0] bird_y;
  logic       touched, frame_tick;

  int total = 0;
  int bad   = 0;

  // Hand-computed fall trajectory: velocity 0,1,2,3 then capped at 4, clamped at 108.
  int fall_exp [15] = '{60, 61, 63, 66, 70, 74, 78, 82, 86, 90, 94, 98, 102, 106, 108};

  bird_datapath #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .move      (move),
    .press_key (press_key),
    .pipe_x    (pipe_x),
    .gap_top   (gap_top),
    .gap_bottom(gap_bottom),
    .bird_y    (bird_y),
    .touched   (touched),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; move = 1'b0; press_key = 1'b0;
    pipe_x = 8'd200; gap_top = 7'd0; gap_bottom = 7'd127;
    #3;
    check("rst_y", 32'(bird_y), 60);
    check("rst_touched", 32'(touched), 0);
    check("rst_ft", 32'(frame_tick), 0);
    step(2);
    reset = 1'b0;
    $display("reset: bird_y=%0d touched=%0d", bird_y, touched);

    // Free fall from start to the ground clamp.
    start = 1'b1; step(1); start = 1'b0;
    move = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step(3);
      check("fall_ft_gap", 32'(frame_tick), 0);
      step(1);
      check("fall_y", 32'(bird_y), 32'(fall_exp[k]));
      check("fall_ft", 32'(frame_tick), 1);
      $display("fall tick %0d: bird_y=%0d frame_tick=%0d touched=%0d", k, bird_y, frame_tick, touched);
    end
    check("fall_touch_pre", 32'(touched), 0);
    step(1);
    check("ground_touched", 32'(touched), 1);
    step(12);
    check("ground_hold_y", 32'(bird_y), 108);
    check("ground_hold_ft", 32'(frame_tick), 0);
    check("ground_hold_t", 32'(touched), 1);
    $display("ground: bird_y=%0d touched=%0d", bird_y, touched);

    // Restart while move stays high; counter restarts from 0.
    start = 1'b1; step(1); start = 1'b0;
    check("restart_y", 32'(bird_y), 60);
    check("restart_touched", 32'(touched), 0);
    step(3);
    check("restart_ft_gap", 32'(frame_tick), 0);
    step(1);
    check("restart_ft", 32'(frame_tick), 1);
    check("restart_y1", 32'(bird_y), 60);
    step(4);
    check("restart_y2", 32'(bird_y), 61);
    $display("restart: bird_y=%0d frame_tick=%0d", bird_y, frame_tick);

    // Asynchronous reset while frame_tick is high.
    reset = 1'b1;
    #1;
    check("async_ft", 32'(frame_tick), 0);
    check("async_y", 32'(bird_y), 60);
    check("async_touched", 32'(touched), 0);
    step(2);
    check("async_hold_ft", 32'(frame_tick), 0);
    reset = 1'b0;
    step(3);
    check("postrst_ft_gap", 32'(frame_tick), 0);
    step(1);
    check("postrst_ft", 32'(frame_tick), 1);
    step(4);
    check("postrst_y", 32'(bird_y), 61);
    $display("after reset: bird_y=%0d", bird_y);

    // Rising to the ceiling.
    press_key = 1'b1;
    start = 1'b1; step(1); start = 1'b0;
    check("rise_start_y", 32'(bird_y), 60);
    for (int k = 1; k <= 30; k++) begin
      step(4);
      check("rise_y", 32'(bird_y), 32'(60 - 2 * k));
      $display("rise tick %0d: bird_y=%0d touched=%0d", k, bird_y, touched);
    end
    check("rise_touch_pre", 32'(touched), 0);
    step(1);
    check("ceiling_touched", 32'(touched), 1);
    step(8);
    check("ceiling_hold_y", 32'(bird_y), 0);
    check("ceiling_hold_ft", 32'(frame_tick), 0);
    press_key = 1'b0;

    // Pipe collisions: move low holds, column edges, gap edges.
    move = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    pipe_x = 8'd18; gap_top = 7'd70; gap_bottom = 7'd90;
    step(1);
    check("pipe_nomove", 32'(touched), 0);
    pipe_x = 8'd24; move = 1'b1;
    step(1);
    check("pipe_col_right", 32'(touched), 0);
    pipe_x = 8'd12;
    step(1);
    check("pipe_col_left", 32'(touched), 0);
    pipe_x = 8'd13;
    step(1);
    check("pipe_col_hit", 32'(touched), 1);
    $display("pipe: pipe_x=%0d touched=%0d", pipe_x, touched);

    pipe_x = 8'd18; gap_top = 7'd50; gap_bottom = 7'd80;
    start = 1'b1; step(1); start = 1'b0;
    check("gap_clear", 32'(touched), 0);
    step(3);
    check("gap_wide", 32'(touched), 0);
    step(1);
    check("gap_tick1_y", 32'(bird_y), 60);
    gap_top = 7'd60; gap_bottom = 7'd63;
    step(3);
    check("gap_edges", 32'(touched), 0);
    step(1);
    check("gap_tick2_y", 32'(bird_y), 61);
    check("gap_tick2_t", 32'(touched), 0);
    step(1);
    check("gap_latency", 32'(touched), 1);
    $display("gap: bird_y=%0d touched=%0d", bird_y, touched);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
